riscv_lsu: RTL

Load/store unit between the execute stage and the data RAM. Consumes the ALU-computed effective address, store data and funct3 for LOAD_S and STORE_S instructions. Drives a word-addressed RAM port with per-byte enables over a req/gnt/rvalid handshake. Returns the aligned, sign- or zero-extended load result for register writeback, or an error for misaligned or illegal accesses.

---
 rtl/riscv_lsu.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit: takes a decoded LOAD/STORE from execute, drives a
// word-addressed byte-enabled RAM port over req/gnt/rvalid, and returns an
// aligned, extended load result (or an error) as a single-cycle response.
module riscv_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int RAM_AMOUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [REG_ADDR-1:0]   req_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [RAM_AMOUNT-1:0] mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    output logic                  rsp_we_rd,
    output logic [REG_ADDR-1:0]   rsp_rd,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_q;
    logic                  req_ready_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [RAM_AMOUNT-1:0] mem_be_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_we_rd_q;
    logic [REG_ADDR-1:0]   rsp_rd_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;

    // Request context kept for the data phase
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [REG_ADDR-1:0]   rd_q;

    // Decode of the incoming request
    logic                  ok_d;
    logic [RAM_AMOUNT-1:0] be_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    // Selects the addressed lane and sign- or zero-extends per funct3.
    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [1:0]            off,
        input logic [2:0]            f3
    );
        logic [DATA_WIDTH-1:0] s;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  extract_load = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
            3'b001:  extract_load = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
            3'b100:  extract_load = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
            3'b101:  extract_load = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
            default: extract_load = s;
        endcase
    endfunction

    // Legality, alignment, byte enables and lane-replicated store data
    always_comb begin
        logic legal;
        logic aligned;
        legal   = 1'b0;
        aligned = 1'b0;
        be_d    = '0;
        wdata_d = req_wdata;
        if (req_we)
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        case (req_funct3[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_d    = RAM_AMOUNT'(4'b0001) << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                aligned = ~req_addr[0];
                be_d    = RAM_AMOUNT'(4'b0011) << req_addr[1:0];
                wdata_d = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                aligned = (req_addr[1:0] == 2'b00);
                be_d    = '1;
            end
            default: aligned = 1'b0;
        endcase
        ok_d = legal && aligned;
    end

    // Control FSM with registered outputs; reset aborts any transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_rd_q <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        off_q       <= req_addr[1:0];
                        rd_q        <= req_rd;
                        if (ok_d) begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_we_rd_q <= 1'b0;
                            rsp_data_q  <= '0;
                            rsp_rd_q    <= req_rd;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        if (we_q) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_we_rd_q <= 1'b0;
                            rsp_data_q  <= '0;
                            rsp_rd_q    <= rd_q;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_we_rd_q <= 1'b1;
                        rsp_data_q  <= extract_load(mem_rdata, off_q, funct3_q);
                        rsp_rd_q    <= rd_q;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_we_rd_q <= 1'b0;
                    rsp_data_q  <= '0;
                    rsp_rd_q    <= '0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we_rd = rsp_we_rd_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
